// File: rtl/maxnet_engine_if.sv
// maxnet_engine_if: start/done handshake, operands and results of the MaxNet engine.
// The engine side uses the slave modport, the requester side the master modport.
interface maxnet_engine_if #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int MAX_ITER = 64
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_ITER + 1);

  logic           i_start;
  logic [W-1:0]   i_eps;
  logic [N*W-1:0] i_num;
  logic           o_busy;
  logic           o_done;
  logic           o_found;
  logic           o_timeout;
  logic [IW-1:0]  o_winner;
  logic [W-1:0]   o_max;
  logic [CW-1:0]  o_iterCount;

  modport master (
    output i_start, i_eps, i_num,
    input  o_busy, o_done, o_found, o_timeout, o_winner, o_max, o_iterCount
  );

  modport slave (
    input  i_start, i_eps, i_num,
    output o_busy, o_done, o_found, o_timeout, o_winner, o_max, o_iterCount
  );
endinterface

// File: rtl/maxnet_engine.sv
// maxnet_engine: winner-take-all MaxNet with one shared multiplier and a start/done handshake.
// Define MAXNET_SAT_EN to clamp the scaled product and difference to W bits instead of wrapping.
module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int FRAC     = 16,
  parameter int MAX_ITER = 64
) (
  input logic            i_clk,
  input logic            i_rst,
  maxnet_engine_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_ITER + 1);
  localparam int SW = W + IW;
  localparam int PW = 2 * W + IW + 1;

  localparam logic [W-1:0]  W_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  W_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [IW:0]   P_ONE    = (IW+1)'(1);
  localparam logic [CW-1:0] ITER_END = CW'(MAX_ITER);

`ifdef MAXNET_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, SUM, UPDATE, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic signed [W-1:0]  r_x  [N];
  logic signed [W-1:0]  r_b  [N];
  logic signed [W-1:0]  r_bn [N];
  logic [W-1:0]         r_eps;
  logic signed [SW-1:0] r_sum;
  logic [IW-1:0]        r_k;
  logic [CW-1:0]        r_iter;
  logic                 r_found;
  logic                 r_timeout;
  logic [IW-1:0]        r_winner;
  logic [W-1:0]         r_max;

  logic [IW:0]          w_pCount;
  logic [IW-1:0]        w_winIdx;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_diff;
  logic signed [PW-1:0] w_shift;
  logic                 w_pOvf;
  logic signed [W-1:0]  w_p;
  logic [W:0]           w_a;
  logic signed [W-1:0]  w_aFit;
  logic signed [W-1:0]  w_bn;

  function automatic logic isPos(input logic [W-1:0] v);
    return !v[W-1] && (|v);
  endfunction

  // Survivor count, the surviving index (meaningful only when exactly one) and the total activity
  always_comb begin
    w_pCount = '0;
    w_winIdx = '0;
    w_sum    = '0;
    for (int i = 0; i < N; i++) begin
      if (isPos(r_b[i])) begin
        w_pCount = w_pCount + P_ONE;
        w_winIdx = IW'(i);
      end
      w_sum = w_sum + SW'(r_b[i]);
    end
  end

  // Shared inhibition datapath for channel r_k; inhibition is the sum of all other channels
  always_comb begin
    w_diff  = r_sum - SW'(r_b[r_k]);
    w_shift = ($signed({{(PW-W){1'b0}}, r_eps}) * PW'(w_diff)) >>> FRAC;
    w_pOvf  = (w_shift[PW-1:W-1] != {(PW-W+1){w_shift[PW-1]}});
    if (SAT_EN && w_pOvf) w_p = w_shift[PW-1] ? W_MIN : W_MAX;
    else                  w_p = w_shift[W-1:0];
    w_a = {r_b[r_k][W-1], r_b[r_k]} - {w_p[W-1], w_p};
    if (SAT_EN && (w_a[W] != w_a[W-1])) w_aFit = w_a[W] ? W_MIN : W_MAX;
    else                                w_aFit = w_a[W-1:0];
    w_bn = isPos(w_aFit) ? w_aFit : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_next = LOAD;
      LOAD:    w_next = CHECK;
      CHECK:   if ((w_pCount == P_ONE) || (w_pCount == '0) || (r_iter == ITER_END)) w_next = DONE;
               else w_next = SUM;
      SUM:     w_next = UPDATE;
      UPDATE:  if (r_k == IW'(N - 1)) w_next = CHECK;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy = (r_state != IDLE);
    bus.o_done = (r_state == DONE);
  end

  // New activities land in r_bn; the last channel's value bypasses it so the array swaps in one edge
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < N; i++) begin
        r_x[i]  <= '0;
        r_b[i]  <= '0;
        r_bn[i] <= '0;
      end
      r_eps     <= '0;
      r_sum     <= '0;
      r_k       <= '0;
      r_iter    <= '0;
      r_found   <= 1'b0;
      r_timeout <= 1'b0;
      r_winner  <= '0;
      r_max     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            for (int i = 0; i < N; i++) r_x[i] <= bus.i_num[i*W +: W];
            r_eps <= bus.i_eps;
          end
        end
        LOAD: begin
          for (int i = 0; i < N; i++) r_b[i] <= isPos(r_x[i]) ? r_x[i] : '0;
          r_found   <= 1'b0;
          r_timeout <= 1'b0;
          r_winner  <= '0;
          r_max     <= '0;
          r_iter    <= '0;
        end
        CHECK: begin
          if (w_pCount == P_ONE) begin
            r_found  <= 1'b1;
            r_winner <= w_winIdx;
            r_max    <= r_x[w_winIdx];
          end else if ((w_pCount != '0) && (r_iter == ITER_END)) begin
            r_timeout <= 1'b1;
          end
        end
        SUM: begin
          r_sum <= w_sum;
          r_k   <= '0;
        end
        UPDATE: begin
          r_bn[r_k] <= w_bn;
          r_k       <= r_k + IW'(1);
          if (r_k == IW'(N - 1)) begin
            for (int i = 0; i < N; i++) r_b[i] <= (i == N - 1) ? w_bn : r_bn[i];
            r_iter <= r_iter + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_found     = r_found;
  assign bus.o_timeout   = r_timeout;
  assign bus.o_winner    = r_winner;
  assign bus.o_max       = r_max;
  assign bus.o_iterCount = r_iter;
endmodule

// File: tb/tb_maxnet_engine.sv
// tb_maxnet_engine: directed and randomized runs of maxnet_engine scored against a
// wide-integer MaxNet model; expected results are queued at start and checked on done.
`timescale 1ns/1ps
module tb_maxnet_engine;
  localparam int N          = 4;
  localparam int W          = 32;
  localparam int FRAC       = 16;
  localparam int MAX_ITER   = 64;
  localparam int IW         = $clog2(N);
  localparam int CW         = $clog2(MAX_ITER + 1);
  localparam int RUN_BUDGET = 3 + MAX_ITER * (N + 2) + 20;
  localparam logic signed [127:0] VMAX = (128'sd1 <<< (W - 1)) - 128'sd1;
  localparam logic signed [127:0] VMIN = -(128'sd1 <<< (W - 1));

  typedef struct {
    logic          found;
    logic          timeout;
    logic [IW-1:0] winner;
    logic [W-1:0]  maxv;
    logic [CW-1:0] iters;
    int            doneCycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   nVectors = 0;
  int   nMiscompares = 0;
  exp_t expQ[$];
  exp_t lastExp;

  maxnet_engine_if #(.N(N), .W(W), .MAX_ITER(MAX_ITER)) bus ();

  maxnet_engine #(.N(N), .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [127:0] fitW(input logic signed [127:0] v);
    logic signed [W-1:0] low;
`ifdef MAXNET_SAT_EN
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
`endif
    low = v[W-1:0];
    return 128'(low);
  endfunction

  // Reference: exact integer MaxNet iterations, reduced to W bits only where the engine narrows
  function automatic exp_t refModel(input logic [N*W-1:0] numv, input logic [W-1:0] e, input int t0);
    logic signed [127:0] x[N];
    logic signed [127:0] b[N];
    logic signed [127:0] bn[N];
    logic signed [127:0] s, p, a;
    logic signed [W-1:0] xi;
    int   pos, last, iters;
    bit   stop;
    exp_t r;
    for (int i = 0; i < N; i++) begin
      xi   = numv[i*W +: W];
      x[i] = 128'(xi);
      b[i] = (x[i] > 128'sd0) ? x[i] : 128'sd0;
    end
    r.found = 1'b0; r.timeout = 1'b0; r.winner = '0; r.maxv = '0;
    iters = 0;
    stop  = 1'b0;
    while (!stop) begin
      pos = 0; last = 0;
      for (int i = 0; i < N; i++) if (b[i] > 128'sd0) begin pos++; last = i; end
      if (pos == 1) begin
        r.found = 1'b1; r.winner = IW'(last); r.maxv = x[last][W-1:0]; stop = 1'b1;
      end else if (pos == 0) begin
        stop = 1'b1;
      end else if (iters == MAX_ITER) begin
        r.timeout = 1'b1; stop = 1'b1;
      end else begin
        s = 128'sd0;
        for (int i = 0; i < N; i++) s = s + b[i];
        for (int k = 0; k < N; k++) begin
          p     = fitW(($signed(128'(e)) * (s - b[k])) >>> FRAC);
          a     = fitW(b[k] - p);
          bn[k] = (a > 128'sd0) ? a : 128'sd0;
        end
        for (int i = 0; i < N; i++) b[i] = bn[i];
        iters++;
      end
    end
    r.iters     = CW'(iters);
    r.doneCycle = t0 + 3 + iters * (N + 2);
    return r;
  endfunction

  function automatic logic [N*W-1:0] packNum(input logic [W-1:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " busy"},      bus.o_busy,      1'b0);
    checkOutput({tag, " done"},      bus.o_done,      1'b0);
    checkOutput({tag, " found"},     bus.o_found,     1'b0);
    checkOutput({tag, " timeout"},   bus.o_timeout,   1'b0);
    checkOutput({tag, " winner"},    bus.o_winner,    '0);
    checkOutput({tag, " max"},       bus.o_max,       '0);
    checkOutput({tag, " iterCount"}, bus.o_iterCount, '0);
  endtask

  // Issue one run once the engine is idle and queue its expected result
  task automatic applyStimulus(input logic [N*W-1:0] numv, input logic [W-1:0] e, input bit keepStart);
    int t0;
    @(negedge clk);
    for (int i = 0; i < RUN_BUDGET && bus.o_busy; i++) @(negedge clk);
    checkOutput("idle before start", bus.o_busy, 1'b0);
    bus.i_num   = numv;
    bus.i_eps   = e;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    expQ.push_back(refModel(numv, e, t0));
    checkOutput("busy in load", bus.o_busy, 1'b1);
    if (!keepStart) bus.i_start = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < RUN_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run finished in budget", expQ.size(), 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    checkOutput("held found",     bus.o_found,     lastExp.found);
    checkOutput("held max",       bus.o_max,       lastExp.maxv);
    checkOutput("held iterCount", bus.o_iterCount, lastExp.iters);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_done) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious done", bus.o_done, 1'b0);
        end else begin
          e = expQ.pop_front();
          lastExp = e;
          checkOutput("found",      bus.o_found,     e.found);
          checkOutput("timeout",    bus.o_timeout,   e.timeout);
          checkOutput("winner",     bus.o_winner,    e.winner);
          checkOutput("max",        bus.o_max,       e.maxv);
          checkOutput("iterCount",  bus.o_iterCount, e.iters);
          checkOutput("busy in done", bus.o_busy,    1'b1);
          checkOutput("done cycle", cyc + 1,         e.doneCycle);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, required under %0d", cyc, 200_000);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N*W-1:0] v;
    logic [N*W-1:0] case1;
    logic [W-1:0]   ch;
    logic [W-1:0]   e;
    int             n;
    lastExp = '{default: '0};
    case1 = packNum(32'h0005_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000);
    bus.i_start = 1'b0;
    bus.i_eps   = '0;
    bus.i_num   = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("power-up reset");
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(case1, 32'h0000_2000, 1'b0);
    waitDrain();
    applyStimulus(packNum(32'hFFFE_0000, 32'h0, 32'h0007_0000, 32'h0), 32'h0000_2000, 1'b0);
    waitDrain();

    // Reset while a found result is being held
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkReset("idle reset");
    @(negedge clk); rst = 1'b1;

    applyStimulus(packNum(32'h0004_0000, 32'h0004_0000, 32'h0, 32'h0), 32'h0000_2000, 1'b0);
    waitDrain();
    applyStimulus('0, 32'h0000_2000, 1'b0);
    waitDrain();
    applyStimulus(packNum(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000), 32'h0001_0000, 1'b0);
    waitDrain();

    // start pulsed mid-run must be ignored
    applyStimulus(case1, 32'h0000_2000, 1'b0);
    repeat (4) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_num   = packNum(32'h0, 32'h0009_0000, 32'h0, 32'h0);
    @(negedge clk);
    bus.i_start = 1'b0;
    waitDrain();

    // start held high: the next LOAD follows the first IDLE cycle after DONE
    applyStimulus(packNum(32'hFFFE_0000, 32'h0, 32'h0007_0000, 32'h0), 32'h0000_2000, 1'b1);
    n = 0;
    while (!bus.o_done && n < RUN_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held-start done seen", bus.o_done, 1'b1);
    bus.i_num = case1;
    @(posedge clk); #1;
    checkOutput("held-start idle", bus.o_busy, 1'b0);
    @(posedge clk); #1;
    checkOutput("held-start reload", bus.o_busy, 1'b1);
    expQ.push_back(refModel(case1, 32'h0000_2000, cyc));
    bus.i_start = 1'b0;
    waitDrain();

    // Reset in the second UPDATE cycle aborts the run with no done pulse
    applyStimulus(case1, 32'h0000_2000, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    expQ.delete();
    checkReset("mid-run reset");
    @(negedge clk); rst = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(case1, 32'h0000_2000, 1'b0);
    waitDrain();

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       ch = $urandom;
          1:       ch = $urandom_range(0, 32'h000A_0000) - 32'h0002_0000;
          2:       ch = v[W-1:0];
          default: ch = $urandom_range(0, 32'h0010_0000);
        endcase
        v[i*W +: W] = ch;
      end
      e = (r % 8 == 7) ? $urandom : $urandom_range(32'h0000_0800, 32'h0000_8000);
      applyStimulus(v, e, 1'b0);
      waitDrain();
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule
